mcpu_mem_master: RTL and testbench

CPU-side initiator for the microCPU RAM controller. It accepts load/store requests from the datapath and instruction-fetch requests from the fetch stage, each over a req/ack handshake. It sequences the RAM controller's level-sensitive we/re/addr/datawr and instraddr inputs so that writes never land on a transitional address. It captures datard/instrrd into registered outputs after a programmable settle time.

---
 rtl/mcpu_mem_pkg.sv | 33 +++
 rtl/mcpu_fetch_channel.sv | 73 +++++++
 rtl/mcpu_mem_master.sv | 128 ++++++++++++
 tb/tb_mcpu_mem_master.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_mem_pkg.sv
// Shared types and helpers for the microCPU memory master: FSM state encodings,
// default widths and the settle-time arithmetic used by both channels.
package mcpu_mem_pkg;

    localparam int DEF_WORD_SIZE  = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        D_IDLE,
        D_SETUP,
        D_WRITE,
        D_HOLD,
        D_READ,
        D_DONE
    } d_state_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_FETCH,
        F_DONE
    } f_state_t;

    // A zero settle time would leave no cycle for the strobe, so it is promoted to one.
    function automatic int eff_wait(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : wait_cycles;
    endfunction

    // Counter holds eff-1 down to 0, so clog2(eff) bits suffice (minimum one bit).
    function automatic int wait_cnt_width(input int eff);
        return (eff > 1) ? $clog2(eff) : 1;
    endfunction

endpackage

// File: rtl/mcpu_fetch_channel.sv
// Instruction-fetch channel: drives the RAM instruction address, waits the settle
// time, registers the returned instruction and pulses f_ack for one cycle.
module mcpu_fetch_channel
    import mcpu_mem_pkg::*;
#(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_ack,
    output logic [WORD_SIZE-1:0]  f_instr,
    output logic [ADDR_WIDTH-1:0] ram_instraddr,
    input  logic [WORD_SIZE-1:0]  ram_instrrd
);

    localparam int EFF = eff_wait(WAIT_CYCLES);
    localparam int CW  = wait_cnt_width(EFF);
    localparam logic [CW-1:0] CNT_LOAD = CW'(EFF - 1);

    f_state_t              state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [WORD_SIZE-1:0]  instr_nxt;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = ram_instraddr;
        instr_nxt = f_instr;
        case (state)
            F_IDLE: begin
                if (f_req) begin
                    addr_nxt  = f_addr;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = F_FETCH;
                end
            end
            F_FETCH: begin
                if (cnt == '0) begin
                    instr_nxt = ram_instrrd;
                    state_nxt = F_DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            F_DONE:  state_nxt = F_IDLE;
            default: state_nxt = F_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= F_IDLE;
            cnt           <= '0;
            ram_instraddr <= '0;
            f_instr       <= '0;
            f_ack         <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            ram_instraddr <= addr_nxt;
            f_instr       <= instr_nxt;
            f_ack         <= (state_nxt == F_DONE);
        end
    end

endmodule

// File: rtl/mcpu_mem_master.sv
// CPU-side initiator for the microCPU RAM controller: sequences glitch-free
// store/load strobes on the data port and runs an independent fetch channel.
module mcpu_mem_master
    import mcpu_mem_pkg::*;
#(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_SIZE-1:0]  d_wdata,
    output logic                  d_ack,
    output logic [WORD_SIZE-1:0]  d_rdata,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_ack,
    output logic [WORD_SIZE-1:0]  f_instr,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_SIZE-1:0]  ram_datawr,
    input  logic [WORD_SIZE-1:0]  ram_datard,
    output logic [ADDR_WIDTH-1:0] ram_instraddr,
    input  logic [WORD_SIZE-1:0]  ram_instrrd
);

    localparam int EFF = eff_wait(WAIT_CYCLES);
    localparam int CW  = wait_cnt_width(EFF);
    localparam logic [CW-1:0] CNT_LOAD = CW'(EFF - 1);

    d_state_t              state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  wr_q, wr_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [WORD_SIZE-1:0]  wdata_nxt;
    logic [WORD_SIZE-1:0]  rdata_nxt;

    // Address and write data are registered at acceptance, so they are already
    // stable during SETUP and stay untouched through WRITE and HOLD.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_nxt    = wr_q;
        addr_nxt  = ram_addr;
        wdata_nxt = ram_datawr;
        rdata_nxt = d_rdata;
        case (state)
            D_IDLE: begin
                if (d_req) begin
                    wr_nxt    = d_wr;
                    addr_nxt  = d_addr;
                    if (d_wr) begin
                        wdata_nxt = d_wdata;
                    end
                    state_nxt = D_SETUP;
                end
            end
            D_SETUP: begin
                cnt_nxt   = CNT_LOAD;
                state_nxt = wr_q ? D_WRITE : D_READ;
            end
            D_WRITE: begin
                if (cnt == '0) begin
                    state_nxt = D_HOLD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            D_HOLD: state_nxt = D_DONE;
            D_READ: begin
                if (cnt == '0) begin
                    rdata_nxt = ram_datard;
                    state_nxt = D_DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            D_DONE:  state_nxt = D_IDLE;
            default: state_nxt = D_IDLE;
        endcase
    end

    // Strobes and ack decode the next state, so they are registered and aligned
    // with the state they belong to; reset clears them without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= D_IDLE;
            cnt        <= '0;
            wr_q       <= 1'b0;
            ram_addr   <= '0;
            ram_datawr <= '0;
            d_rdata    <= '0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            d_ack      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wr_q       <= wr_nxt;
            ram_addr   <= addr_nxt;
            ram_datawr <= wdata_nxt;
            d_rdata    <= rdata_nxt;
            ram_we     <= (state_nxt == D_WRITE);
            ram_re     <= (state_nxt == D_READ);
            d_ack      <= (state_nxt == D_DONE);
        end
    end

    mcpu_fetch_channel #(
        .WORD_SIZE   (WORD_SIZE),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_fetch (
        .clk           (clk),
        .rst_n         (rst_n),
        .f_req         (f_req),
        .f_addr        (f_addr),
        .f_ack         (f_ack),
        .f_instr       (f_instr),
        .ram_instraddr (ram_instraddr),
        .ram_instrrd   (ram_instrrd)
    );

endmodule

// File: tb/tb_mcpu_mem_master.sv
// Scoreboard bench for mcpu_mem_master: three builds (WAIT_CYCLES 1, 3, 0) each run
// directed scenarios plus concurrent random data/fetch traffic against a memory model.
module tb_mcpu_mem_master;

    localparam int WS = 8;
    localparam int AW = 8;
    localparam int NI = 3;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [WS-1:0] data;
        int            t0;
    } d_exp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WS-1:0] data;
        int            t0;
    } f_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    task automatic check(input string name, input int inst, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (wait=%0d) got=%0h expected=%0h", name, inst, act, exp);
        end
    endtask

    function automatic int wc_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    // Initial RAM contents; 0x40 holds the instruction used by the concurrent scenario.
    function automatic logic [WS-1:0] pre_val(input logic [AW-1:0] a);
        if (a == 8'h40) return 8'h7E;
        return WS'(a * 29 + 113);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gen_env
        localparam int WC     = wc_of(g);
        localparam int EFF    = (WC < 1) ? 1 : WC;
        localparam int LAT_ST = EFF + 3;
        localparam int LAT_LD = EFF + 2;
        localparam int LAT_F  = EFF + 1;

        logic          rst_n = 1'b1;
        logic          d_req = 1'b0, d_wr = 1'b0, f_req = 1'b0;
        logic [AW-1:0] d_addr = '0, f_addr = '0;
        logic [WS-1:0] d_wdata = '0;
        logic          d_ack, f_ack, ram_we, ram_re;
        logic [WS-1:0] d_rdata, f_instr, ram_datawr, ram_datard, ram_instrrd;
        logic [AW-1:0] ram_addr, ram_instraddr;

        mcpu_mem_master #(
            .WORD_SIZE   (WS),
            .ADDR_WIDTH  (AW),
            .WAIT_CYCLES (WC)
        ) dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .d_req         (d_req),
            .d_wr          (d_wr),
            .d_addr        (d_addr),
            .d_wdata       (d_wdata),
            .d_ack         (d_ack),
            .d_rdata       (d_rdata),
            .f_req         (f_req),
            .f_addr        (f_addr),
            .f_ack         (f_ack),
            .f_instr       (f_instr),
            .ram_we        (ram_we),
            .ram_re        (ram_re),
            .ram_addr      (ram_addr),
            .ram_datawr    (ram_datawr),
            .ram_datard    (ram_datard),
            .ram_instraddr (ram_instraddr),
            .ram_instrrd   (ram_instrrd)
        );

        // Level-sensitive RAM controller model: writes while we is high, reads combinationally.
        bit [WS-1:0] ram [256];
        bit          wrt [256];
        always @(posedge clk) begin
            if (ram_we) begin
                ram[ram_addr] <= ram_datawr;
                wrt[ram_addr] <= 1'b1;
            end
        end
        assign ram_datard  = wrt[ram_addr] ? ram[ram_addr] : pre_val(ram_addr);
        assign ram_instrrd = wrt[ram_instraddr] ? ram[ram_instraddr] : pre_val(ram_instraddr);

        logic [WS-1:0] exp_mem [256];
        d_exp_t dq[$];
        f_exp_t fq[$];
        d_exp_t e_d;
        f_exp_t e_f;
        int we_w = 0, re_w = 0, both = 0;
        logic [AW-1:0] prev_addr = '0;
        logic [WS-1:0] prev_wd = '0;

        // Monitor: checks strobes against the active transaction and pops on each ack.
        always @(negedge clk) begin
            if (!rst_n) begin
                we_w = 0;
                re_w = 0;
            end else begin
                if (ram_we && ram_re) both++;
                if (ram_we) begin
                    if (dq.size() == 0) begin
                        check("we_spurious", WC, 64'(ram_we), 64'd0);
                    end else begin
                        check("we_addr_data", WC, {ram_addr, ram_datawr}, {dq[0].addr, dq[0].data});
                        if (we_w == 0)
                            check("we_setup_stable", WC, {prev_addr, prev_wd}, {dq[0].addr, dq[0].data});
                    end
                    we_w++;
                end else if (we_w != 0) begin
                    check("we_width", WC, we_w, EFF);
                    if (dq.size() != 0)
                        check("we_hold_stable", WC, {ram_addr, ram_datawr}, {dq[0].addr, dq[0].data});
                    we_w = 0;
                end
                if (ram_re) begin
                    if (re_w == 0 && dq.size() != 0)
                        check("re_addr", WC, ram_addr, dq[0].addr);
                    re_w++;
                end else if (re_w != 0) begin
                    check("re_width", WC, re_w, EFF);
                    re_w = 0;
                end
                if (d_ack) begin
                    if (dq.size() == 0) begin
                        check("d_ack_spurious", WC, 64'(d_ack), 64'd0);
                    end else begin
                        e_d = dq.pop_front();
                        check(e_d.wr ? "store_latency" : "load_latency", WC, cyc - e_d.t0,
                              e_d.wr ? LAT_ST : LAT_LD);
                        if (!e_d.wr) check("d_rdata", WC, d_rdata, e_d.data);
                    end
                end
                if (f_ack) begin
                    if (fq.size() == 0) begin
                        check("f_ack_spurious", WC, 64'(f_ack), 64'd0);
                    end else begin
                        e_f = fq.pop_front();
                        check("fetch_latency", WC, cyc - e_f.t0, LAT_F);
                        check("f_instr", WC, f_instr, e_f.data);
                    end
                end
            end
            prev_addr = ram_addr;
            prev_wd   = ram_datawr;
        end

        task automatic wait_d_ack();
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!d_ack && n < 60);
            if (!d_ack) check("d_ack_timeout", WC, 64'(d_ack), 64'd1);
        endtask

        task automatic wait_f_ack();
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!f_ack && n < 60);
            if (!f_ack) check("f_ack_timeout", WC, 64'(f_ack), 64'd1);
        endtask

        // Called at a negedge while the DUT is idle; returns at a negedge in IDLE.
        task automatic do_data(input bit wr, input logic [AW-1:0] a, input logic [WS-1:0] wd,
                               input bit early_drop);
            d_req = 1'b1; d_wr = wr; d_addr = a; d_wdata = wd;
            dq.push_back('{wr: wr, addr: a, data: wr ? wd : exp_mem[a], t0: cyc});
            if (wr) exp_mem[a] = wd;
            if (early_drop) begin
                @(negedge clk);
                d_req = 1'b0; d_wr = ~wr; d_addr = ~a; d_wdata = ~wd;
            end
            wait_d_ack();
            d_req = 1'b0;
            @(negedge clk);
        endtask

        task automatic do_fetch(input logic [AW-1:0] a);
            f_req = 1'b1; f_addr = a;
            fq.push_back('{addr: a, data: exp_mem[a], t0: cyc});
            wait_f_ack();
            f_req = 1'b0;
            @(negedge clk);
        endtask

        task automatic back_to_back_loads(input logic [AW-1:0] a0);
            d_req = 1'b1; d_wr = 1'b0; d_addr = a0;
            for (int k = 0; k < 3; k++)
                dq.push_back('{wr: 1'b0, addr: AW'(a0 + k), data: exp_mem[AW'(a0 + k)],
                               t0: cyc + k * (LAT_LD + 1)});
            for (int k = 0; k < 3; k++) begin
                wait_d_ack();
                d_addr = AW'(a0 + k + 1);
            end
            d_req = 1'b0;
            @(negedge clk);
        endtask

        task automatic reset_mid_write();
            int n = 0;
            int acks = 0;
            d_req = 1'b1; d_wr = 1'b1; d_addr = 8'h55; d_wdata = exp_mem[8'h55];
            dq.push_back('{wr: 1'b1, addr: 8'h55, data: exp_mem[8'h55], t0: cyc});
            do begin
                @(negedge clk);
                n++;
            end while (!ram_we && n < 20);
            check("we_reached", WC, 64'(ram_we), 64'd1);
            #2 rst_n = 1'b0;
            #1 check("we_async_drop", WC, {ram_we, ram_re}, 64'd0);
            d_req = 1'b0;
            dq.delete();
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (d_ack) acks++;
            end
            check("no_ack_after_abort", WC, acks, 0);
        endtask

        task automatic random_data(input int n_ops);
            bit            wr;
            logic [AW-1:0] a;
            logic [WS-1:0] wd;
            for (int i = 0; i < n_ops; i++) begin
                wr = 1'($urandom_range(0, 1));
                a  = AW'($urandom_range(0, 127));
                wd = WS'($urandom);
                do_data(wr, a, wd, 1'b0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        endtask

        task automatic random_fetch(input int n_ops);
            for (int i = 0; i < n_ops; i++) begin
                do_fetch(AW'($urandom_range(128, 255)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        endtask

        initial begin
            for (int a = 0; a < 256; a++) exp_mem[a] = pre_val(AW'(a));
            #1 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("reset_outputs", WC, {d_ack, d_rdata, f_ack, f_instr, ram_we, ram_re,
                                        ram_addr, ram_datawr, ram_instraddr}, 64'd0);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            check("idle_outputs", WC, {d_ack, d_rdata, f_ack, f_instr, ram_we, ram_re,
                                       ram_addr, ram_datawr, ram_instraddr}, 64'd0);

            do_data(1'b1, 8'h3C, 8'hA5, 1'b0);
            do_data(1'b0, 8'h3C, 8'h00, 1'b0);

            // Store and fetch accepted on the same edge.
            d_req = 1'b1; d_wr = 1'b1; d_addr = 8'h20; d_wdata = 8'h11;
            f_req = 1'b1; f_addr = 8'h40;
            dq.push_back('{wr: 1'b1, addr: 8'h20, data: 8'h11, t0: cyc});
            fq.push_back('{addr: 8'h40, data: exp_mem[8'h40], t0: cyc});
            exp_mem[8'h20] = 8'h11;
            fork
                begin wait_d_ack(); d_req = 1'b0; end
                begin wait_f_ack(); f_req = 1'b0; end
            join
            @(negedge clk);
            do_data(1'b0, 8'h20, 8'h00, 1'b0);

            back_to_back_loads(8'h3B);
            do_data(1'b1, 8'h66, 8'hC3, 1'b1);
            do_data(1'b0, 8'h66, 8'h00, 1'b0);

            reset_mid_write();
            do_data(1'b1, 8'hFF, 8'h5A, 1'b0);
            do_data(1'b0, 8'hFF, 8'h00, 1'b0);
            do_fetch(8'hFF);
            do_data(1'b0, 8'h00, 8'h00, 1'b0);

            fork
                random_data(40);
                random_fetch(40);
            join
            repeat (4) @(negedge clk);
            check("we_re_exclusive", WC, both, 0);
            check("d_queue_drained", WC, dq.size(), 0);
            check("f_queue_drained", WC, fq.size(), 0);
            done_cnt++;
        end
    end

    initial begin
        int n = 0;
        while (done_cnt < NI && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < NI) check("global_timeout", -1, done_cnt, NI);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
